// File: rtl/drv_sd_arbiter.sv
// rtl/drv_sd_arbiter.sv - round-robin sharing of one host SD block port among NDRV drives
//
// Each drive's track loader drives level-held rd/wr requests as if it owned the
// host SD port. This block grants one drive at a time in round-robin order,
// forwards that drive's LBA/block count to the host, and routes the host ack,
// buffer write strobe and write data back to/from the granted drive only.
//
// Ports:
//   clk, reset         clk_sys clock, synchronous active-high reset
//   drv_lba            per-drive LBA, drive i at [32*i+:32]
//   drv_blk_cnt        per-drive block count-1, drive i at [6*i+:6]
//   drv_rd / drv_wr    per-drive level requests, held until own ack rises
//   drv_ack            per-drive ack (host ack gated to the granted drive)
//   drv_buff_din       per-drive write data, drive i at [8*i+:8]
//   drv_buff_wr        per-drive buffer write strobe (gated to granted drive)
//   sd_lba/sd_blk_cnt  host LBA / block count, latched at grant
//   sd_rd / sd_wr      host requests, dropped once sd_ack rises
//   sd_ack             host ack, high for the whole transfer
//   sd_buff_wr         host buffer write strobe
//   sd_buff_din        write data to host, muxed from the granted drive
//   grant              index of the current/last granted drive
//   busy               a transfer is requested or in progress
//   err                one-cycle pulse when a request times out
//
// Optional feature (macro DRV_SD_ARB_WATCHDOG_EN): a REQ-phase watchdog that
// abandons a request after TIMEOUT cycles without sd_ack and pulses err.
// Without the macro, REQ waits indefinitely and err is constant 0.

module drv_sd_arbiter #(
    parameter int          NDRV    = 2,
    parameter logic [23:0] TIMEOUT = 24'd16000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NDRV*32-1:0]   drv_lba,
    input  logic [NDRV*6-1:0]    drv_blk_cnt,
    input  logic [NDRV-1:0]      drv_rd,
    input  logic [NDRV-1:0]      drv_wr,
    output logic [NDRV-1:0]      drv_ack,
    input  logic [NDRV*8-1:0]    drv_buff_din,
    output logic [NDRV-1:0]      drv_buff_wr,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    logic [1:0]      state;
    logic [1:0]      rr;
    logic [1:0]      rr_next;

    logic [NDRV-1:0] pending;
    logic            any_pending;
    logic [1:0]      sel;
    int              sel_dist;
    int              best_dist;
    logic [31:0]     sel_lba;
    logic [5:0]      sel_blk_cnt;
    logic            sel_rd;
    logic            sel_wr;

    // ------------------------------------------------------------------
    // Round-robin pick: the pending drive with the smallest forward
    // distance from the rr pointer (wrapping modulo NDRV) wins.
    // ------------------------------------------------------------------
    always_comb begin
        pending     = drv_rd | drv_wr;
        any_pending = |pending;
        sel         = 2'd0;
        best_dist   = NDRV;
        sel_dist    = 0;
        for (int i = 0; i < NDRV; i++) begin
            sel_dist = (i >= int'(rr)) ? (i - int'(rr)) : (i + NDRV - int'(rr));
            if (pending[i] && (sel_dist < best_dist)) begin
                best_dist = sel_dist;
                sel       = 2'(i);
            end
        end
    end

    // Request fields of the selected drive. A simultaneous rd+wr is served
    // as the write; the read stays pending on the drive side.
    always_comb begin
        sel_lba     = '0;
        sel_blk_cnt = '0;
        sel_rd      = 1'b0;
        sel_wr      = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (sel == 2'(i)) begin
                sel_lba     = drv_lba[32*i +: 32];
                sel_blk_cnt = drv_blk_cnt[6*i +: 6];
                sel_wr      = drv_wr[i];
                sel_rd      = drv_rd[i] & ~drv_wr[i];
            end
        end
    end

    // Pointer moves one past the drive just served; with NDRV==1 it stays 0.
    assign rr_next = (grant == 2'(NDRV - 1)) ? 2'd0 : (grant + 2'd1);

    // ------------------------------------------------------------------
    // Return path: ack, strobe and write data follow the granted drive.
    // Kept combinational so drv_buff_wr lines up with the externally
    // broadcast buffer address.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NDRV; i++) begin
            drv_ack[i] = sd_ack & busy & (grant == 2'(i));
        end
    end

    assign drv_buff_wr = drv_ack & {NDRV{sd_buff_wr}};

    always_comb begin
        sd_buff_din = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (grant == 2'(i)) begin
                sd_buff_din = drv_buff_din[8*i +: 8];
            end
        end
    end

`ifdef DRV_SD_ARB_WATCHDOG_EN
    logic [23:0] wd_cnt;
    logic        err_q;

    assign err = err_q;
`else
    logic unused_timeout;

    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr         <= 2'd0;
            grant      <= 2'd0;
            busy       <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
`ifdef DRV_SD_ARB_WATCHDOG_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef DRV_SD_ARB_WATCHDOG_EN
            err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // A host ack still high (e.g. left over from a reset
                    // mid-transfer) belongs to nobody; wait for it to drop.
                    if (!sd_ack && any_pending) begin
                        grant      <= sel;
                        sd_lba     <= sel_lba;
                        sd_blk_cnt <= sel_blk_cnt;
                        sd_wr      <= sel_wr;
                        sd_rd      <= sel_rd;
                        busy       <= 1'b1;
                        state      <= ST_REQ;
`ifdef DRV_SD_ARB_WATCHDOG_EN
                        wd_cnt     <= '0;
`endif
                    end
                end

                ST_REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= ST_XFER;
                    end
`ifdef DRV_SD_ARB_WATCHDOG_EN
                    else if (wd_cnt == (TIMEOUT - 24'd1)) begin
                        // Give up on this drive; it may request again but
                        // the others get their turn first.
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        err_q <= 1'b1;
                        busy  <= 1'b0;
                        rr    <= rr_next;
                        state <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 24'd1;
                    end
`endif
                end

                ST_XFER: begin
                    if (!sd_ack) begin
                        busy  <= 1'b0;
                        rr    <= rr_next;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drv_sd_arbiter.sv
// tb/tb_drv_sd_arbiter.sv - self-checking bench for drv_sd_arbiter (NDRV=2, TIMEOUT=100)
module tb_drv_sd_arbiter;

    localparam int NDRV = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NDRV*32-1:0]  drv_lba = '0;
    logic [NDRV*6-1:0]   drv_blk_cnt = '0;
    logic [NDRV-1:0]     drv_rd = '0;
    logic [NDRV-1:0]     drv_wr = '0;
    logic [NDRV-1:0]     drv_ack;
    logic [NDRV*8-1:0]   drv_buff_din = '0;
    logic [NDRV-1:0]     drv_buff_wr;
    logic [31:0]         sd_lba;
    logic [5:0]          sd_blk_cnt;
    logic                sd_rd;
    logic                sd_wr;
    logic                sd_ack = 1'b0;
    logic                sd_buff_wr = 1'b0;
    logic [7:0]          sd_buff_din;
    logic [1:0]          grant;
    logic                busy;
    logic                err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    drv_sd_arbiter #(.NDRV(NDRV), .TIMEOUT(24'd100)) dut (
        .clk          (clk),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_blk_cnt  (drv_blk_cnt),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_din (drv_buff_din),
        .drv_buff_wr  (drv_buff_wr),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .grant        (grant),
        .busy         (busy),
        .err          (err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Clears drive-side stimulus and pulses reset; sd_ack is left as the caller set it.
    task automatic apply_reset();
        drv_rd = '0; drv_wr = '0; drv_lba = '0; drv_blk_cnt = '0;
        drv_buff_din = '0; sd_buff_wr = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Host acks the outstanding request, drives drop, ack falls; ends in IDLE.
    task automatic host_finish();
        sd_ack = 1'b1;
        tick();
        drv_rd = '0; drv_wr = '0; sd_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        sd_ack = 1'b0;
        apply_reset();
        n_cmp++; if (sd_rd !== 1'b0) begin n_bad++; $display("FAIL reset_sd_rd: got %b expected 0", sd_rd); end
        n_cmp++; if (sd_wr !== 1'b0) begin n_bad++; $display("FAIL reset_sd_wr: got %b expected 0", sd_wr); end
        n_cmp++; if (sd_lba !== 32'h0) begin n_bad++; $display("FAIL reset_sd_lba: got %h expected 0", sd_lba); end
        n_cmp++; if (sd_blk_cnt !== 6'h0) begin n_bad++; $display("FAIL reset_sd_blk_cnt: got %h expected 0", sd_blk_cnt); end
        n_cmp++; if (grant !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d expected 0", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (drv_ack !== 2'b00) begin n_bad++; $display("FAIL reset_drv_ack: got %b expected 00", drv_ack); end
    endtask

    task automatic test_single_read();
        drv_lba[63:32] = 32'h0000_0123;
        drv_blk_cnt[11:6] = 6'd5;
        drv_rd = 2'b10;
        tick();
        n_cmp++; if (sd_rd !== 1'b1) begin n_bad++; $display("FAIL single_sd_rd: got %b expected 1", sd_rd); end
        n_cmp++; if (sd_wr !== 1'b0) begin n_bad++; $display("FAIL single_sd_wr: got %b expected 0", sd_wr); end
        n_cmp++; if (sd_lba !== 32'h123) begin n_bad++; $display("FAIL single_sd_lba: got %h expected 00000123", sd_lba); end
        n_cmp++; if (sd_blk_cnt !== 6'd5) begin n_bad++; $display("FAIL single_blk_cnt: got %0d expected 5", sd_blk_cnt); end
        n_cmp++; if (grant !== 2'd1) begin n_bad++; $display("FAIL single_grant: got %0d expected 1", grant); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick(); tick(); tick();
        n_cmp++; if (sd_rd !== 1'b1) begin n_bad++; $display("FAIL single_req_hold: got %b expected 1", sd_rd); end
        sd_ack = 1'b1;
        #1;
        n_cmp++; if (drv_ack !== 2'b10) begin n_bad++; $display("FAIL single_ack_comb: got %b expected 10", drv_ack); end
        tick();
        n_cmp++; if (sd_rd !== 1'b0) begin n_bad++; $display("FAIL single_rd_drop: got %b expected 0", sd_rd); end
        n_cmp++; if (drv_ack !== 2'b10) begin n_bad++; $display("FAIL single_ack_xfer: got %b expected 10", drv_ack); end
        drv_rd = 2'b00;
        tick(); tick();
        sd_ack = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        n_cmp++; if (drv_ack !== 2'b00) begin n_bad++; $display("FAIL single_ack_end: got %b expected 00", drv_ack); end
        // rr must have wrapped back to drive 0
        drv_rd = 2'b11;
        tick();
        n_cmp++; if (grant !== 2'd0) begin n_bad++; $display("FAIL single_rr_wrap: got %0d expected 0", grant); end
        host_finish();
    endtask

    task automatic test_contention();
        sd_ack = 1'b0;
        apply_reset();
        drv_rd = 2'b11;
        tick();
        n_cmp++; if (grant !== 2'd0 || sd_rd !== 1'b1) begin n_bad++; $display("FAIL contend_first: got grant %0d rd %b expected grant 0 rd 1", grant, sd_rd); end
        sd_ack = 1'b1;
        tick();
        drv_rd[0] = 1'b0;
        tick();
        sd_ack = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL contend_idle_gap: got busy %b expected 0", busy); end
        tick();
        n_cmp++; if (grant !== 2'd1 || sd_rd !== 1'b1) begin n_bad++; $display("FAIL contend_second: got grant %0d rd %b expected grant 1 rd 1", grant, sd_rd); end
        drv_rd[0] = 1'b1;
        sd_ack = 1'b1;
        tick();
        drv_rd[1] = 1'b0;
        sd_ack = 1'b0;
        tick();
        tick();
        n_cmp++; if (grant !== 2'd0 || sd_rd !== 1'b1) begin n_bad++; $display("FAIL contend_third: got grant %0d rd %b expected grant 0 rd 1", grant, sd_rd); end
        host_finish();
    endtask

    task automatic test_write_priority();
        sd_ack = 1'b0;
        apply_reset();
        drv_buff_din = {8'h3C, 8'hA5};
        drv_wr = 2'b01;
        drv_rd = 2'b01;
        tick();
        n_cmp++; if (sd_wr !== 1'b1 || sd_rd !== 1'b0) begin n_bad++; $display("FAIL wprio_dir: got wr %b rd %b expected wr 1 rd 0", sd_wr, sd_rd); end
        sd_ack = 1'b1;
        tick();
        drv_wr[0] = 1'b0;
        sd_buff_wr = 1'b1;
        #1;
        n_cmp++; if (sd_buff_din !== 8'hA5) begin n_bad++; $display("FAIL wprio_din: got %h expected a5", sd_buff_din); end
        n_cmp++; if (drv_buff_wr !== 2'b01) begin n_bad++; $display("FAIL wprio_strobe: got %b expected 01", drv_buff_wr); end
        tick();
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        tick();
        tick();
        n_cmp++; if (grant !== 2'd0 || sd_rd !== 1'b1 || sd_wr !== 1'b0) begin n_bad++; $display("FAIL wprio_later_rd: got grant %0d rd %b wr %b expected 0 1 0", grant, sd_rd, sd_wr); end
        host_finish();
    endtask

    task automatic test_strobe_isolation();
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            sd_buff_wr = i[0];
            sd_ack = i[1];
            #1;
            if (drv_buff_wr !== 2'b00 || drv_ack !== 2'b00) bad++;
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        tick();
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL strobe_iso: got %0d leaking cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid_xfer();
        int early;
        sd_ack = 1'b0;
        apply_reset();
        drv_lba[31:0] = 32'hDEAD_BEEF;
        drv_rd = 2'b01;
        tick();
        sd_ack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if ({sd_rd, sd_wr, busy, err, grant, drv_ack} !== 7'b0) begin n_bad++; $display("FAIL rstmid_ctl: got rd%b wr%b busy%b err%b grant%0d ack%b expected all 0", sd_rd, sd_wr, busy, err, grant, drv_ack); end
        n_cmp++; if (sd_lba !== 32'h0) begin n_bad++; $display("FAIL rstmid_lba: got %h expected 0", sd_lba); end
        reset = 1'b0;
        drv_rd = 2'b10;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || sd_rd !== 1'b0) early++;
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL rstmid_blocked: got %0d early grants expected 0", early); end
        sd_ack = 1'b0;
        tick();
        n_cmp++; if (sd_rd !== 1'b1 || grant !== 2'd1) begin n_bad++; $display("FAIL rstmid_regrant: got rd %b grant %0d expected rd 1 grant 1", sd_rd, grant); end
        host_finish();
    endtask

`ifdef DRV_SD_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int hi;
        int saw_err;
        sd_ack = 1'b0;
        apply_reset();
        drv_rd = 2'b01;
        tick();
        drv_rd[1] = 1'b1;
        hi = 0;
        saw_err = 0;
        for (int c = 0; c < 300 && sd_rd; c++) begin
            hi++;
            if (err) saw_err++;
            tick();
        end
        n_cmp++; if (hi !== 100) begin n_bad++; $display("FAIL wd_req_cycles: got %0d expected 100", hi); end
        n_cmp++; if (saw_err !== 0) begin n_bad++; $display("FAIL wd_early_err: got %0d expected 0", saw_err); end
        n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL wd_abort: got err %b busy %b expected err 1 busy 0", err, busy); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wd_err_pulse: got %b expected 0", err); end
        n_cmp++; if (grant !== 2'd1 || sd_rd !== 1'b1) begin n_bad++; $display("FAIL wd_next_grant: got grant %0d rd %b expected 1 1", grant, sd_rd); end
        host_finish();
    endtask
`else
    task automatic test_watchdog();
        int bad_rd;
        int bad_err;
        sd_ack = 1'b0;
        apply_reset();
        drv_rd = 2'b01;
        tick();
        bad_rd = 0;
        bad_err = 0;
        for (int c = 0; c < 1100; c++) begin
            if (sd_rd !== 1'b1) bad_rd++;
            if (err !== 1'b0) bad_err++;
            tick();
        end
        n_cmp++; if (bad_rd !== 0) begin n_bad++; $display("FAIL nowd_rd_held: got %0d dropped cycles expected 0", bad_rd); end
        n_cmp++; if (bad_err !== 0) begin n_bad++; $display("FAIL nowd_err: got %0d err cycles expected 0", bad_err); end
        host_finish();
    endtask
`endif

    // Random drives and host against a transaction-level reference.
    task automatic test_random(input int ncyc);
        int              m_phase;   // 0 idle, 1 waiting for host ack, 2 host transferring
        int              m_rr;
        int              m_grant;
        logic [31:0]     m_lba;
        logic [5:0]      m_cnt;
        logic            m_rd;
        logic            m_wr;
        int              h_state;
        int              h_cnt;
        int              pick;
        int              found;
        int              r;
        logic [NDRV-1:0] pend;
        logic [NDRV-1:0] exp_ack;
        logic [7:0]      exp_din;

        sd_ack = 1'b0;
        apply_reset();
        m_phase = 0; m_rr = 0; m_grant = 0; m_lba = '0; m_cnt = '0; m_rd = 1'b0; m_wr = 1'b0;
        h_state = 0; h_cnt = 0;

        for (int c = 0; c < ncyc; c++) begin
            tick();
            // Reference update from the inputs the DUT sampled at this edge.
            pend = drv_rd | drv_wr;
            if (m_phase == 0) begin
                if (!sd_ack && pend != '0) begin
                    found = 0;
                    pick = 0;
                    for (int k = 0; k < NDRV; k++) begin
                        if (found == 0 && pend[(m_rr + k) % NDRV]) begin
                            found = 1;
                            pick = (m_rr + k) % NDRV;
                        end
                    end
                    m_grant = pick;
                    m_lba = drv_lba[32*pick +: 32];
                    m_cnt = drv_blk_cnt[6*pick +: 6];
                    m_wr = drv_wr[pick];
                    m_rd = drv_rd[pick] & ~drv_wr[pick];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (sd_ack) begin
                    m_rd = 1'b0;
                    m_wr = 1'b0;
                    m_phase = 2;
                end
            end else begin
                if (!sd_ack) begin
                    m_phase = 0;
                    m_rr = (m_grant + 1) % NDRV;
                end
            end

            exp_ack = '0;
            if (m_phase != 0 && sd_ack) exp_ack[m_grant] = 1'b1;
            exp_din = drv_buff_din[8*m_grant +: 8];

            n_cmp++; if (busy !== (m_phase != 0)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, (m_phase != 0)); end
            n_cmp++; if (grant !== 2'(m_grant)) begin n_bad++; $display("FAIL rnd_grant c%0d: got %0d expected %0d", c, grant, m_grant); end
            n_cmp++; if (sd_rd !== m_rd || sd_wr !== m_wr) begin n_bad++; $display("FAIL rnd_rdwr c%0d: got rd %b wr %b expected rd %b wr %b", c, sd_rd, sd_wr, m_rd, m_wr); end
            n_cmp++; if (sd_lba !== m_lba || sd_blk_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_lba c%0d: got %h/%0d expected %h/%0d", c, sd_lba, sd_blk_cnt, m_lba, m_cnt); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rnd_err c%0d: got %b expected 0", c, err); end
            n_cmp++; if (drv_ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack c%0d: got %b expected %b", c, drv_ack, exp_ack); end
            n_cmp++; if (drv_buff_wr !== (exp_ack & {NDRV{sd_buff_wr}})) begin n_bad++; $display("FAIL rnd_buff_wr c%0d: got %b expected %b", c, drv_buff_wr, exp_ack & {NDRV{sd_buff_wr}}); end
            n_cmp++; if (sd_buff_din !== exp_din) begin n_bad++; $display("FAIL rnd_din c%0d: got %h expected %h", c, sd_buff_din, exp_din); end

            // Drives: hold request until own ack, then drop; sometimes raise a new one.
            for (int i = 0; i < NDRV; i++) begin
                if ((drv_rd[i] | drv_wr[i]) && drv_ack[i]) begin
                    drv_rd[i] = 1'b0;
                    drv_wr[i] = 1'b0;
                end else if (!(drv_rd[i] | drv_wr[i]) && !drv_ack[i] && $urandom_range(0, 3) == 0) begin
                    r = int'($urandom_range(0, 2));
                    drv_lba[32*i +: 32] = $urandom;
                    drv_blk_cnt[6*i +: 6] = 6'($urandom_range(0, 63));
                    drv_rd[i] = (r != 1);
                    drv_wr[i] = (r != 0);
                end
                drv_buff_din[8*i +: 8] = 8'($urandom);
            end

            // Host: random ack delay and transfer length; strobe toggles freely.
            sd_buff_wr = 1'($urandom_range(0, 1));
            if (h_state == 0) begin
                if (sd_rd | sd_wr) begin
                    h_cnt = int'($urandom_range(0, 3));
                    h_state = 1;
                end
            end
            if (h_state == 1) begin
                if (h_cnt == 0) begin
                    sd_ack = 1'b1;
                    h_cnt = int'($urandom_range(1, 4));
                    h_state = 2;
                end else begin
                    h_cnt--;
                end
            end else if (h_state == 2) begin
                if (h_cnt == 0) begin
                    sd_ack = 1'b0;
                    h_state = 0;
                end else begin
                    h_cnt--;
                end
            end
        end
        drv_rd = '0; drv_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_priority();
        test_strobe_isolation();
        test_reset_mid_xfer();
        test_watchdog();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drv_sd_arbiter.md
Name: drv_sd_arbiter

Overview:
- Shares one host SD block interface (lba/blk_cnt/rd/wr/ack/buff) among NDRV drive instances.
- Each drive's track loader issues level-held rd/wr requests as if it owned the port.
- Round-robin arbitration; one transfer in flight at a time.
- Sits in the clk_sys domain between the drive array and the HPS/QNICE SD bridge.

Parameters:
- NDRV, 2, number of drive requesters (1..4).
- TIMEOUT, 24'd16000000, clk cycles allowed from request to sd_ack rise (only with watchdog macro).

Ports:
- clk  in  1  clk_sys clock
- reset  in  1  synchronous, active-high
- drv_lba  in  NDRV*32  per-drive LBA, drive i at [32*i+:32]
- drv_blk_cnt  in  NDRV*6  per-drive block count-1, [6*i+:6]
- drv_rd  in  NDRV  per-drive read request (level, held until own ack rises)
- drv_wr  in  NDRV  per-drive write request (level, held until own ack rises)
- drv_ack  out  NDRV  per-drive ack
- drv_buff_din  in  NDRV*8  per-drive write data, [8*i+:8]
- drv_buff_wr  out  NDRV  per-drive buffer write strobe
- sd_lba  out  32  host LBA
- sd_blk_cnt  out  6  host block count
- sd_rd  out  1  host read request
- sd_wr  out  1  host write request
- sd_ack  in  1  host ack (high for the whole transfer)
- sd_buff_wr  in  1  host buffer write strobe
- sd_buff_din  out  8  write data to host
- grant  out  2  index of the current/last granted drive
- busy  out  1  transfer in REQ or XFER
- err  out  1  one-cycle timeout pulse

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, grant=0, busy=0, err=0, rr pointer=0, state=IDLE.
- Reset mid-transfer drops everything to IDLE at once.
- States:
  - IDLE:
    - Requires sd_ack==0 before granting. If sd_ack is still high after reset, it stays in IDLE until ack falls.
    - pending[i] = drv_rd[i]|drv_wr[i].
    - Selects the first pending index at or after rr, wrapping modulo NDRV.
    - On the next edge: grant<=sel; sd_lba/sd_blk_cnt latch from drive sel; sd_wr<=drv_wr[sel]; sd_rd<=drv_rd[sel]&~drv_wr[sel] (write wins); busy<=1; state<=REQ.
    - Latency: request visible at edge N gives sd_rd/sd_wr high after edge N+1.
  - REQ:
    - Holds sd_lba/sd_rd/sd_wr stable.
    - On sd_ack==1: sd_rd<=0, sd_wr<=0, state<=XFER.
  - XFER:
    - On sd_ack==0: state<=IDLE, busy<=0, rr<=(grant+1) mod NDRV.
    - The next grant can occur in the cycle after returning to IDLE.
- Ack and strobes:
  - drv_ack[i] = sd_ack & busy & (grant==i), combinational.
  - drv_buff_wr[i] = sd_buff_wr & drv_ack[i], combinational, so it aligns with sd_buff_addr, which is broadcast externally.
  - sd_buff_din = drv_buff_din[grant], combinational mux.
  - Non-granted drives always see ack=0 and buff_wr=0.
- Requests and priority:
  - Requests are never withdrawn by the arbiter. A drive dropping its request during REQ does not abort the transfer.
  - A drive whose request appears while another is served waits; FIFO order is not kept, rr order applies.
  - NDRV==1: rr stays 0 and the block degenerates to a registered pass-through.
  - Simultaneous rd and wr from the same drive: the write is served; the rd is served in a later grant if still held.

Optional Feature:
- Macro DRV_SD_ARB_WATCHDOG_EN.
- When defined:
  - A 24-bit counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT with sd_ack still 0: sd_rd/sd_wr<=0, err pulses high for 1 cycle, rr<=grant+1, state<=IDLE.
  - The failed drive may re-request.
- When undefined: REQ waits indefinitely, err is tied 0, and no counter exists.

Test Plan:
- Single read, NDRV=2: drv_rd[1]=1, drv_lba[1]=0x00000123 at edge 0 -> sd_rd=1, sd_lba=0x123, grant=1 after edge 1. Host raises ack at edge 5 -> sd_rd=0 at edge 6, drv_ack[1]=1, drv_ack[0]=0. Ack falls -> busy=0, rr=0.
- Contention: drv_rd=2'b11 from reset -> drive 0 served first. Drive 1 is granted on the second IDLE cycle after drive 0's ack falls. A third request from drive 0 is then served after drive 1.
- Write priority and data mux: drv_wr[0]=1, drv_rd[0]=1, drv_buff_din[0]=0xA5 -> sd_wr=1, sd_rd=0. During XFER sd_buff_din=0xA5, and sd_buff_wr pulses appear only on drv_buff_wr[0].
- Reset mid-XFER with sd_ack held high: all outputs 0. A new drv_rd[1] is not granted until sd_ack falls, then sd_rd rises one cycle later.
- Watchdog with TIMEOUT=100, macro on: drv_rd[0]=1, no ack -> after 100 REQ cycles sd_rd=0 and err=1 for exactly one cycle. A pending drv_rd[1] is granted next. Macro off: sd_rd stays high for more than 1000 cycles and err stays 0.
- Strobe isolation: sd_buff_wr toggling while busy=0 -> drv_buff_wr=0 for all drives.
